// File: rtl/reg_bus_master.sv
// Register-bus master: accepts single writes and incrementing read bursts, drives a
// register file with fixed read latency RD_LAT and returns read quadlets over a ready/valid port.
module reg_bus_master #(
    parameter int RD_LAT = 2
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_len,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic        wr_en,
    input  logic [31:0] reg_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_WAIT = 2'd2,
        RSP     = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] count;
    logic [2:0] wait_cnt;
    logic       accept;

    // Gating with reset keeps cmd_ready low for the whole time reset is held.
    assign cmd_ready = (state == IDLE) && reset;
    assign accept    = cmd_valid && cmd_ready;
    assign wr_en     = (state == WR);
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = cmd_write ? WR : RD_WAIT;
            WR:      state_nxt = IDLE;
            RD_WAIT: if (wait_cnt == 3'd0) state_nxt = RSP;
            RSP:     if (rsp_ready) state_nxt = (count == 4'd0) ? IDLE : RD_WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            reg_addr  <= 8'd0;
            reg_wdata <= 32'd0;
            count     <= 4'd0;
            wait_cnt  <= 3'd0;
            rsp_data  <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        reg_addr <= cmd_addr;
                        if (cmd_write) begin
                            reg_wdata <= cmd_wdata;
                        end else begin
                            count    <= cmd_len;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                RD_WAIT: begin
                    // Counter is tested before decrementing, so the sample edge lands RD_LAT edges after the address edge.
                    if (wait_cnt == 3'd0) begin
                        rsp_data  <= reg_rdata;
                        rsp_valid <= 1'b1;
                        rsp_last  <= (count == 4'd0);
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (count != 4'd0) begin
                            reg_addr <= reg_addr + 8'd1;
                            count    <= count - 4'd1;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: writes, single and burst reads, backpressure,
// command hold-off and asynchronous reset mid-burst, against a registered register-file model.
module tb_reg_bus_master;

    localparam int RD_LAT = 2;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr  = 8'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic [3:0]  cmd_len   = 4'd0;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        wr_en;
    logic [31:0] reg_rdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        busy;

    int checks = 0;
    int passes = 0;

    reg_bus_master #(.RD_LAT(RD_LAT)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_len   (cmd_len),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .wr_en     (wr_en),
        .reg_rdata (reg_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    function automatic logic [31:0] model_data(input logic [7:0] a);
        if (a == 8'h04) return 32'h514C4131;
        return {8'hD0, a, ~a, a ^ 8'h5A};
    endfunction

    // Register file with a registered read port: one cycle from address to data.
    always @(posedge sysclk) reg_rdata <= model_data(reg_addr);

    // Presents a command from a negedge; called only while the DUT is idle, so the next posedge accepts it.
    task automatic start_cmd(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] l);
        @(negedge sysclk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_len   = l;
        @(posedge sysclk);
        @(negedge sysclk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (reg_addr !== 8'h00) $display("FAIL reset_reg_addr: got %h want 00", reg_addr); else passes++;
        checks++; if (reg_wdata !== 32'h0) $display("FAIL reset_reg_wdata: got %h want 0", reg_wdata); else passes++;
        checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else passes++;
        checks++; if ({rsp_valid, rsp_last} !== 2'b00) $display("FAIL reset_rsp_flags: got %b want 00", {rsp_valid, rsp_last}); else passes++;
        checks++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else passes++;
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL release_cmd_ready: got %b want 1", cmd_ready); else passes++;
    endtask

    task automatic test_write();
        start_cmd(1'b1, 8'h03, 32'h0000_1234, 4'd0);
        checks++; if (wr_en !== 1'b1) $display("FAIL wr_strobe: got %b want 1", wr_en); else passes++;
        checks++; if (reg_addr !== 8'h03) $display("FAIL wr_addr: got %h want 03", reg_addr); else passes++;
        checks++; if (reg_wdata !== 32'h0000_1234) $display("FAIL wr_data: got %h want 00001234", reg_wdata); else passes++;
        checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL wr_busy: got busy=%b ready=%b want 1/0", busy, cmd_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_no_rsp0: got %b want 0", rsp_valid); else passes++;
        @(negedge sysclk);
        checks++; if (wr_en !== 1'b0) $display("FAIL wr_one_cycle: got %b want 0", wr_en); else passes++;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL wr_idle: got busy=%b ready=%b want 0/1", busy, cmd_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_no_rsp1: got %b want 0", rsp_valid); else passes++;
    endtask

    task automatic test_single_read();
        rsp_ready = 1'b0;
        start_cmd(1'b0, 8'h04, 32'h0, 4'd0);
        checks++; if (reg_addr !== 8'h04) $display("FAIL rd1_addr: got %h want 04", reg_addr); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rd1_early0: got %b want 0", rsp_valid); else passes++;
        @(negedge sysclk);
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rd1_early1: got %b want 0", rsp_valid); else passes++;
        @(negedge sysclk);
        checks++; if (rsp_valid !== 1'b1) $display("FAIL rd1_valid_latency: got %b want 1", rsp_valid); else passes++;
        checks++; if (rsp_data !== 32'h514C4131) $display("FAIL rd1_data: got %h want 514c4131", rsp_data); else passes++;
        checks++; if (rsp_last !== 1'b1) $display("FAIL rd1_last: got %b want 1", rsp_last); else passes++;
        rsp_ready = 1'b1;
        @(negedge sysclk);
        rsp_ready = 1'b0;
        checks++; if ({rsp_valid, rsp_last} !== 2'b00) $display("FAIL rd1_clear: got %b want 00", {rsp_valid, rsp_last}); else passes++;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rd1_idle: got ready=%b busy=%b want 1/0", cmd_ready, busy); else passes++;
    endtask

    task automatic test_burst_wrap();
        int n;
        int last_cyc;
        logic [7:0] exp_addr;
        n = 0;
        last_cyc = 0;
        rsp_ready = 1'b1;
        start_cmd(1'b0, 8'hFE, 32'h0, 4'd3);
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            if (cyc > 0) @(negedge sysclk);
            if (rsp_valid === 1'b1) begin
                exp_addr = 8'hFE + 8'(n);
                checks++; if (reg_addr !== exp_addr) $display("FAIL burst_addr%0d: got %h want %h", n, reg_addr, exp_addr); else passes++;
                checks++; if (rsp_data !== model_data(exp_addr)) $display("FAIL burst_data%0d: got %h want %h", n, rsp_data, model_data(exp_addr)); else passes++;
                checks++; if (rsp_last !== (n == 3)) $display("FAIL burst_last%0d: got %b want %b", n, rsp_last, (n == 3)); else passes++;
                if (n == 0) begin
                    checks++; if (cyc != RD_LAT) $display("FAIL burst_first_latency: got %0d want %0d", cyc, RD_LAT); else passes++;
                end else begin
                    checks++; if (cyc - last_cyc != RD_LAT + 1) $display("FAIL burst_spacing%0d: got %0d want %0d", n, cyc - last_cyc, RD_LAT + 1); else passes++;
                end
                last_cyc = cyc;
                n++;
            end
        end
        checks++; if (n != 4) $display("FAIL burst_count: got %0d want 4", n); else passes++;
        @(negedge sysclk);
        rsp_ready = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL burst_end_idle: got %b want 0", busy); else passes++;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        start_cmd(1'b0, 8'h20, 32'h0, 4'd1);
        for (int t = 0; t < 20 && rsp_valid !== 1'b1; t++) @(negedge sysclk);
        checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_first_valid: got %b want 1", rsp_valid); else passes++;
        checks++; if (rsp_data !== model_data(8'h20) || rsp_last !== 1'b0) $display("FAIL bp_first: got %h/%b want %h/0", rsp_data, rsp_last, model_data(8'h20)); else passes++;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== model_data(8'h20) || reg_addr !== 8'h20)
                $display("FAIL bp_hold%0d: got v=%b d=%h a=%h want 1/%h/20", i, rsp_valid, rsp_data, reg_addr, model_data(8'h20));
            else passes++;
        end
        rsp_ready = 1'b1;
        @(negedge sysclk);
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || reg_addr !== 8'h21) $display("FAIL bp_advance: got v=%b a=%h want 0/21", rsp_valid, reg_addr); else passes++;
        for (int t = 0; t < 20 && rsp_valid !== 1'b1; t++) @(negedge sysclk);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== model_data(8'h21) || rsp_last !== 1'b1)
            $display("FAIL bp_second: got v=%b d=%h l=%b want 1/%h/1", rsp_valid, rsp_data, rsp_last, model_data(8'h21));
        else passes++;
        rsp_ready = 1'b1;
        @(negedge sysclk);
        rsp_ready = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL bp_end_idle: got %b want 0", busy); else passes++;
    endtask

    task automatic test_back_to_back();
        int n;
        int extra;
        logic [7:0] exp_addr;
        n = 0;
        extra = 0;
        rsp_ready = 1'b1;
        @(negedge sysclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h40;
        cmd_len   = 4'd2;
        @(posedge sysclk);
        @(negedge sysclk);
        // The next command waits with cmd_valid high; its fields must not disturb the burst.
        cmd_write = 1'b1;
        cmd_addr  = 8'h55;
        cmd_wdata = 32'hCAFE_F00D;
        cmd_len   = 4'hF;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge sysclk);
            if (busy !== 1'b1) break;
            checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_holdoff%0d: got %b want 0", cyc, cmd_ready); else passes++;
            if (rsp_valid === 1'b1) begin
                exp_addr = 8'h40 + 8'(n);
                checks++; if (rsp_data !== model_data(exp_addr) || reg_addr !== exp_addr)
                    $display("FAIL b2b_rsp%0d: got d=%h a=%h want %h/%h", n, rsp_data, reg_addr, model_data(exp_addr), exp_addr);
                else passes++;
                n++;
            end
        end
        checks++; if (n != 3) $display("FAIL b2b_count: got %0d want 3", n); else passes++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_after: got %b want 1", cmd_ready); else passes++;
        @(posedge sysclk);
        @(negedge sysclk);
        cmd_valid = 1'b0;
        checks++; if (wr_en !== 1'b1 || reg_addr !== 8'h55 || reg_wdata !== 32'hCAFE_F00D)
            $display("FAIL b2b_next_write: got w=%b a=%h d=%h want 1/55/cafef00d", wr_en, reg_addr, reg_wdata);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            @(negedge sysclk);
            if (wr_en === 1'b1 || rsp_valid === 1'b1) extra++;
        end
        checks++; if (extra != 0) $display("FAIL b2b_once: got %0d extra strobes want 0", extra); else passes++;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midburst();
        int activity;
        activity = 0;
        rsp_ready = 1'b1;
        start_cmd(1'b0, 8'h80, 32'h0, 4'd7);
        for (int t = 0; t < 20 && rsp_valid !== 1'b1; t++) @(negedge sysclk);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== model_data(8'h80)) $display("FAIL rst_pre_rsp: got v=%b d=%h want 1/%h", rsp_valid, rsp_data, model_data(8'h80)); else passes++;
        @(negedge sysclk);
        checks++; if (busy !== 1'b1 || reg_addr !== 8'h81) $display("FAIL rst_pre_wait: got busy=%b a=%h want 1/81", busy, reg_addr); else passes++;
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL rst_mid_state: got busy=%b ready=%b want 0/0", busy, cmd_ready); else passes++;
        checks++; if (reg_addr !== 8'h00 || reg_wdata !== 32'h0) $display("FAIL rst_mid_regs: got a=%h d=%h want 00/0", reg_addr, reg_wdata); else passes++;
        checks++; if (rsp_data !== 32'h0 || rsp_valid !== 1'b0 || rsp_last !== 1'b0 || wr_en !== 1'b0)
            $display("FAIL rst_mid_rsp: got d=%h v=%b l=%b w=%b want 0/0/0/0", rsp_data, rsp_valid, rsp_last, wr_en);
        else passes++;
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_release: got ready=%b busy=%b want 1/0", cmd_ready, busy); else passes++;
        for (int i = 0; i < 12; i++) begin
            @(negedge sysclk);
            if (rsp_valid === 1'b1 || wr_en === 1'b1 || busy === 1'b1) activity++;
        end
        checks++; if (activity != 0) $display("FAIL rst_aborted: got %0d active cycles want 0", activity); else passes++;
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_single_read();
        test_burst_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_midburst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passes, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
